// File: rtl/npu_layer_seq_pkg.sv
// Shared definitions for the NPU layer sequencer: FSM state codes, size defaults
// and the state-to-strobe decode used by the top.
package npu_layer_seq_pkg;

   localparam int CW_DEF      = 16;
   localparam int NW_DEF      = 8;
   localparam int SHIFT_N_DEF = 4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_ACC   = 3'd2;
   localparam logic [2:0] ST_RELU  = 3'd3;
   localparam logic [2:0] ST_PLOAD = 3'd4;
   localparam logic [2:0] ST_SHIFT = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   typedef struct packed {
      logic en_buf_in;
      logic clr_buf_in;
      logic en_mac;
      logic rst_mac;
      logic en_relu;
      logic clr_piso_out;
      logic en_piso_out;
      logic shift_out;
      logic wr_en;
   } strobe_t;

   // Moore decode: strobes depend on the registered state only.
   function automatic strobe_t decode_strobes(input logic [2:0] st);
      strobe_t s;
      s = '0;
      case (st)
         ST_LOAD: begin
            s.rst_mac      = 1'b1;
            s.clr_buf_in   = 1'b1;
            s.clr_piso_out = 1'b1;
         end
         ST_ACC: begin
            s.en_mac    = 1'b1;
            s.en_buf_in = 1'b1;
         end
         ST_RELU:  s.en_relu     = 1'b1;
         ST_PLOAD: s.en_piso_out = 1'b1;
         ST_SHIFT: begin
            s.shift_out = 1'b1;
            s.wr_en     = 1'b1;
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/npu_down_counter.sv
// Loadable down counter that saturates at zero; tc flags the last count (value==1).
// One-cycle load/decrement, no wrap.
module npu_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         tc
);

   always_ff @(posedge clk) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (en && (value != '0)) begin
         value <= value - W'(1);
      end
   end

   assign tc = (value == W'(1));

endmodule

// File: rtl/npu_layer_seq.sv
// Layer sequencer: per neuron LOAD, ACC x len, RELU, PLOAD, SHIFT x SHIFT_N, looped cfg_nout times.
// enable=0 freezes all state and zeroes the strobes; abort ends the run via DONE on the next cycle.
module npu_layer_seq
   import npu_layer_seq_pkg::*;
#(
   parameter int CW      = CW_DEF,
   parameter int NW      = NW_DEF,
   parameter int SHIFT_N = SHIFT_N_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] cfg_len,
   input  logic [NW-1:0] cfg_nout,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          en_buf_in,
   output logic          clr_buf_in,
   output logic          en_mac,
   output logic          rst_mac,
   output logic          en_relu,
   output logic          clr_piso_out,
   output logic          en_piso_out,
   output logic          shift_out,
   output logic          wr_en,
   output logic [NW-1:0] neuron_idx,
   output logic [CW-1:0] mac_cnt
);

   localparam int SW = $clog2(SHIFT_N + 1);

   logic [2:0]    state;
   logic [CW-1:0] len_q;
   logic [NW-1:0] nout_q;
   logic [SW-1:0] shift_cnt;
   logic          mac_tc;
   logic          shift_tc;
   logic          run_abort;
   logic          step;
   strobe_t       stb;

   // Abort only matters mid-run; in IDLE it merely blocks a simultaneous start.
   assign run_abort = abort && (state != ST_IDLE) && (state != ST_DONE);
   assign step      = enable && !run_abort;

   npu_down_counter #(.W(CW)) u_mac_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (step && (state == ST_LOAD)),
      .en       (step && (state == ST_ACC)),
      .load_val (len_q),
      .value    (mac_cnt),
      .tc       (mac_tc)
   );

   npu_down_counter #(.W(SW)) u_shift_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (step && (state == ST_PLOAD)),
      .en       (step && (state == ST_SHIFT)),
      .load_val (SW'(SHIFT_N)),
      .value    (shift_cnt),
      .tc       (shift_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         err        <= 1'b0;
         len_q      <= '0;
         nout_q     <= '0;
         neuron_idx <= '0;
      end else if (enable) begin
         if (run_abort) begin
            state <= ST_DONE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     if ((cfg_len == '0) || (cfg_nout == '0)) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                     end else begin
                        len_q      <= cfg_len;
                        nout_q     <= cfg_nout;
                        err        <= 1'b0;
                        neuron_idx <= '0;
                        state      <= ST_LOAD;
                     end
                  end
               end
               ST_LOAD:  state <= ST_ACC;
               ST_ACC:   if (mac_tc) state <= ST_RELU;
               ST_RELU:  state <= ST_PLOAD;
               ST_PLOAD: state <= ST_SHIFT;
               ST_SHIFT: begin
                  if (shift_tc) begin
                     // Compare before incrementing so an all-ones neuron count never wraps.
                     if (neuron_idx == nout_q - NW'(1)) begin
                        state <= ST_DONE;
                     end else begin
                        neuron_idx <= neuron_idx + NW'(1);
                        state      <= ST_LOAD;
                     end
                  end
               end
               ST_DONE:  state <= ST_IDLE;
               default:  state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      stb = '0;
      if (step) stb = decode_strobes(state);
   end

   assign en_buf_in    = stb.en_buf_in;
   assign clr_buf_in   = stb.clr_buf_in;
   assign en_mac       = stb.en_mac;
   assign rst_mac      = stb.rst_mac;
   assign en_relu      = stb.en_relu;
   assign clr_piso_out = stb.clr_piso_out;
   assign en_piso_out  = stb.en_piso_out;
   assign shift_out    = stb.shift_out;
   assign wr_en        = stb.wr_en;

   assign done = enable && (state == ST_DONE);
   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_npu_layer_seq.sv
// Bench for npu_layer_seq: directed table of runs, hand-written corner sequences,
// and randomized runs checked against a cycle-position model of the schedule.
module tb_npu_layer_seq;

   localparam int TCW = 6;
   localparam int TNW = 3;
   localparam int TSN = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           enable = 1'b0;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [TCW-1:0] cfg_len = '0;
   logic [TNW-1:0] cfg_nout = '0;
   logic           busy, done, err;
   logic           en_buf_in, clr_buf_in, en_mac, rst_mac, en_relu;
   logic           clr_piso_out, en_piso_out, shift_out, wr_en;
   logic [TNW-1:0] neuron_idx;
   logic [TCW-1:0] mac_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   npu_layer_seq #(.CW(TCW), .NW(TNW), .SHIFT_N(TSN)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .start        (start),
      .abort        (abort),
      .cfg_len      (cfg_len),
      .cfg_nout     (cfg_nout),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .en_buf_in    (en_buf_in),
      .clr_buf_in   (clr_buf_in),
      .en_mac       (en_mac),
      .rst_mac      (rst_mac),
      .en_relu      (en_relu),
      .clr_piso_out (clr_piso_out),
      .en_piso_out  (en_piso_out),
      .shift_out    (shift_out),
      .wr_en        (wr_en),
      .neuron_idx   (neuron_idx),
      .mac_cnt      (mac_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int len;
      int nout;
      int exp_mac;
      int exp_wr;
      int exp_rst;
      int exp_done;
      int exp_err;
      int exp_idx;
   } vec_t;

   task automatic chk(input string name, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] out_vec();
      return {done, en_buf_in, clr_buf_in, en_mac, rst_mac, en_relu,
              clr_piso_out, en_piso_out, shift_out, wr_en};
   endfunction

   // Start a run and count strobes until done (bounded); we end just after the done cycle.
   task automatic do_run(input int len, input int nout,
                         output int n_mac, output int n_wr, output int n_rst,
                         output int done_cyc, output int err_d, output int idx_d,
                         output int busy_after);
      n_mac = 0; n_wr = 0; n_rst = 0; done_cyc = -1; err_d = -1; idx_d = -1;
      cfg_len = TCW'(len); cfg_nout = TNW'(nout);
      enable = 1'b1; abort = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 1000; c++) begin
         #1;
         n_mac += int'(en_mac);
         n_wr  += int'(wr_en);
         n_rst += int'(rst_mac);
         if (done) begin
            done_cyc = c; err_d = int'(err); idx_d = int'(neuron_idx);
            tick();
            break;
         end
         tick();
      end
      #1;
      busy_after = int'(busy);
   endtask

   // Model: in-run position k fixes the phase by plain arithmetic on len/SHIFT_N.
   task automatic rand_run(input int len, input int nout);
      int P, total, k, guard, n, p;
      logic en;
      logic [9:0] ev;
      longint emac;
      P = len + 3 + TSN;
      total = nout * P + 1;
      cfg_len = TCW'(len); cfg_nout = TNW'(nout);
      enable = 1'b1; abort = 1'b0; start = 1'b1;
      tick();
      k = 1; guard = 0;
      while (k <= total && guard < 4000) begin
         en = ($urandom_range(0, 4) != 0);
         enable = en;
         start = 1'($urandom_range(0, 1));
         cfg_len = TCW'($urandom);
         cfg_nout = TNW'($urandom);
         #1;
         n = (k - 1) / P;
         p = (k - 1) % P;
         ev = '0;
         emac = -1;
         if (k == total) begin
            ev[9] = 1'b1;
            emac = 0;
            chk("rnd_idx", neuron_idx, nout - 1);
         end else begin
            chk("rnd_idx", neuron_idx, n);
            if (p == 0) begin
               ev[7] = 1'b1; ev[5] = 1'b1; ev[3] = 1'b1;
               if (n > 0) emac = 0;
            end else if (p <= len) begin
               ev[8] = 1'b1; ev[6] = 1'b1;
               emac = len - (p - 1);
            end else if (p == len + 1) begin
               ev[4] = 1'b1; emac = 0;
            end else if (p == len + 2) begin
               ev[2] = 1'b1; emac = 0;
            end else begin
               ev[1] = 1'b1; ev[0] = 1'b1; emac = 0;
            end
         end
         chk("rnd_strobes", out_vec(), en ? ev : 10'd0);
         chk("rnd_busy", busy, 1);
         chk("rnd_err", err, 0);
         if (emac >= 0) chk("rnd_mac_cnt", mac_cnt, emac);
         tick();
         if (en) k++;
         guard++;
      end
      if (guard >= 4000) chk("rnd_timeout", guard, 0);
      enable = 1'b1; start = 1'b0;
      #1;
      chk("rnd_idle_after", busy, 0);
   endtask

   vec_t vecs[7];

   initial begin
      int n_mac, n_wr, n_rst, dcyc, errd, idxd, bafter, c;
      vecs[0] = '{3, 1, 3, 4, 1, 11, 0, 0};
      vecs[1] = '{2, 3, 6, 12, 3, 28, 0, 2};
      vecs[2] = '{0, 2, 0, 0, 0, 1, 1, 2};
      vecs[3] = '{4, 2, 8, 8, 2, 23, 0, 1};
      vecs[4] = '{5, 0, 0, 0, 0, 1, 1, 1};
      vecs[5] = '{1, 1, 1, 4, 1, 9, 0, 0};
      vecs[6] = '{63, 7, 441, 28, 7, 491, 0, 6};

      repeat (3) tick();
      reset = 1'b0;
      enable = 1'b1;
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_strobes", out_vec(), 0);
      chk("reset_err", err, 0);
      chk("reset_idx", neuron_idx, 0);
      chk("reset_mac_cnt", mac_cnt, 0);
      tick();

      foreach (vecs[i]) begin
         do_run(vecs[i].len, vecs[i].nout, n_mac, n_wr, n_rst, dcyc, errd, idxd, bafter);
         chk("tbl_en_mac", n_mac, vecs[i].exp_mac);
         chk("tbl_wr_en", n_wr, vecs[i].exp_wr);
         chk("tbl_rst_mac", n_rst, vecs[i].exp_rst);
         chk("tbl_done_cycle", dcyc, vecs[i].exp_done);
         chk("tbl_err", errd, vecs[i].exp_err);
         chk("tbl_idx", idxd, vecs[i].exp_idx);
         chk("tbl_busy_after", bafter, 0);
      end

      // start together with abort in IDLE: abort wins
      cfg_len = 6'd3; cfg_nout = 3'd1; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      #1;
      chk("start_abort_idle_busy", busy, 0);
      chk("start_abort_idle_done", done, 0);
      tick();

      // enable low for 5 cycles mid-ACC while mac_cnt==2
      cfg_len = 6'd4; cfg_nout = 3'd1; start = 1'b1;
      tick();
      start = 1'b0;
      n_mac = 0; c = 0;
      while (c < 50) begin
         #1;
         if (en_mac && mac_cnt == 6'd2) break;
         n_mac += int'(en_mac);
         tick();
         c++;
      end
      chk("freeze_reached", c < 50, 1);
      for (int i = 0; i < 5; i++) begin
         enable = 1'b0;
         #1;
         chk("freeze_strobes", out_vec(), 0);
         chk("freeze_mac_cnt", mac_cnt, 2);
         chk("freeze_busy", busy, 1);
         tick();
      end
      enable = 1'b1;
      c = 0;
      while (c < 50) begin
         #1;
         n_mac += int'(en_mac);
         if (done) break;
         tick();
         c++;
      end
      chk("freeze_total_en_mac", n_mac, 4);
      tick();

      // abort in SHIFT of neuron 1 of 3; a start mid-run must be ignored
      cfg_len = 6'd2; cfg_nout = 3'd3; start = 1'b1;
      tick();
      start = 1'b0;
      c = 1;
      while (c < 100) begin
         start = (c == 3);
         if (c == 3) cfg_len = 6'd9;
         #1;
         if (neuron_idx == 3'd1 && shift_out) break;
         tick();
         c++;
      end
      start = 1'b0;
      chk("abort_reach_cycle", c, 15);
      abort = 1'b1;
      #1;
      chk("abort_strobes", out_vec(), 0);
      tick();
      abort = 1'b0;
      #1;
      chk("abort_done", done, 1);
      chk("abort_err", err, 0);
      tick();
      chk("abort_busy_after", busy, 0);
      chk("abort_done_after", done, 0);

      // synchronous reset mid-ACC
      cfg_len = 6'd5; cfg_nout = 3'd2; start = 1'b1;
      tick();
      start = 1'b0;
      c = 0;
      while (c < 20) begin
         #1;
         if (en_mac) break;
         tick();
         c++;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_mid_strobes", out_vec(), 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_idx", neuron_idx, 0);
      chk("rst_mid_mac_cnt", mac_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_mid_no_done", done, 0);
      end
      do_run(3, 1, n_mac, n_wr, n_rst, dcyc, errd, idxd, bafter);
      chk("rst_fresh_done_cycle", dcyc, 11);
      chk("rst_fresh_wr_en", n_wr, 4);
      chk("rst_fresh_en_mac", n_mac, 3);

      for (int r = 0; r < 15; r++) begin
         rand_run($urandom_range(1, 10), $urandom_range(1, 7));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
